parity_rx_checker: RTL and testbench
====================================

# parity_rx_checker

Serial receive-side parity checker: the consumer end of the team's XOR-based parity generator. It accepts a bit stream of fixed-length frames, each made of DATA_BITS data bits followed by one parity bit, and reassembles the data word. It checks parity, flags mismatches, and keeps an error counter. It sits between a serial link or bit-stimulus source and downstream word-level logic.

## Interface
- DATA_BITS, 3: data bits per frame (≥2); the parity bit follows them.
- ODD_PARITY, 0: 0 = even parity (parity bit = XOR of data bits); 1 = odd (parity bit = XNOR).
- CNT_W, 8: width of the error counter.
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is consumed on this edge.
- in_bit  input  1  serial bit, MSB of data first, parity bit last.
- err_clr  input  1  synchronous clear of err_count.
- out_valid  output  1  one-cycle pulse: frame complete.
- out_data  output  DATA_BITS  received data word, MSB = first bit received.
- out_par_err  output  1  parity mismatch for the frame in out_data.
- err_count  output  CNT_W  saturating count of parity-error frames.

## Operation
- FSM states:
  - DATA: shift in data bits, bit index 0..DATA_BITS-1.
  - PARITY: await the parity bit.
- Reset state is DATA with index 0.
- DATA: on in_valid, shift in_bit into the shift register (left shift, new bit at LSB) and XOR it into the running parity accumulator. Increment the index. On the last data bit, go to PARITY.
- PARITY: on in_valid, compute mismatch = acc ^ in_bit ^ ODD_PARITY, where a nonzero result is an error.
  - Register out_data from the shift register, register out_par_err = mismatch, and pulse out_valid.
  - Clear the accumulator and index, then return to DATA.
- in_valid low: the FSM holds; gaps of any length are allowed anywhere in a frame.
- Back-to-back frames need no idle cycle.
- err_count:
  - Increments by 1 when a frame completes with mismatch.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - err_clr alone sets it to 0.
  - err_clr together with an error completion in the same cycle gives 1: clear first, then count.
- Reset mid-frame discards the partial frame. The next accepted bit is treated as data bit 0.
- out_data and out_par_err hold their values until the next frame completes.

## Timing
- Reset values: out_valid=0, out_data=0, out_par_err=0, err_count=0, FSM=DATA, index=0, accumulator=0.
- Latency: out_valid, out_data and out_par_err become valid on the edge that accepts the parity bit. They are visible in the following cycle, so there is 1 cycle of latency from the parity bit.
- out_valid is high for exactly one cycle per frame.
- err_count updates on the same edge as out_par_err.
- rst takes priority over in_valid and err_clr in the same cycle.
- Minimum frame duration is DATA_BITS+1 cycles.

## Configuration
- PARITY_RX_ERRCNT_EN:
  - Defined: the err_count register, its saturation logic and err_clr are implemented as described.
  - Undefined: no counter logic is built, err_count is tied to 0, and err_clr is ignored.
  - In both cases out_par_err is always present.

## Structure
- Shared package parity_pkg holds:
  - The FSM state enum (PR_DATA, PR_PARITY).
  - The localparam for the index width, $clog2(DATA_BITS).
  - A parity function that the generator side also uses.
- One sub-module, parity_err_counter: a saturating counter with clear, instantiated only under PARITY_RX_ERRCNT_EN.

## Test plan
- Default params: bits 1,0,1 then parity 0 with in_valid held high → one cycle later out_valid=1, out_data=3'b101, out_par_err=0, err_count=0.
- Bits 1,1,1 then parity 0 → out_data=3'b111, out_par_err=1, err_count=1. Repeat with parity 1 → out_par_err=0, err_count stays 1.
- Same frame 1,0,1/0 with in_valid low for 3 cycles between each bit → identical result, and out_valid pulses exactly once.
- Send bits 1,1, assert rst for 1 cycle, then send 0,1,1/0 → out_data=3'b011, out_par_err=0. No spurious out_valid during reset.
- CNT_W=2: send 5 error frames → err_count reads 1,2,3,3,3. Then an error frame with err_clr high in the same cycle → err_count=1. err_clr alone → 0.
- ODD_PARITY=1: 0,0,0/1 → out_par_err=0. With PARITY_RX_ERRCNT_EN undefined, run an error frame → out_par_err=1 and err_count stays 0.

Source files
------------

// File: rtl/parity_pkg.sv
// +------------------------------------------------------------------------+
// | Module   : parity_pkg                                                  |
// | Purpose  : Shared types and helpers for the parity generator/checker.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

package parity_pkg;

  // Receive-side frame FSM: data bits first, then the parity bit
  typedef enum logic [0:0] {
    PR_DATA   = 1'b0,
    PR_PARITY = 1'b1
  } pr_state_t;

  // Default frame length and the matching bit-index width
  localparam int PR_DATA_BITS = 3;
  localparam int PR_IDX_W     = $clog2(PR_DATA_BITS);

  // Index width for an arbitrary frame length (never narrower than 1 bit)
  function automatic int pr_idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Parity bit for a data word: XOR of the bits, inverted for odd parity.
  // Unused upper bits of the 32-bit argument must be zero.
  function automatic logic pr_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage : parity_pkg

`default_nettype wire

// File: rtl/parity_err_counter.sv
// +------------------------------------------------------------------------+
// | Module   : parity_err_counter                                          |
// | Purpose  : Saturating event counter with synchronous clear. A clear    |
// |            and an increment in the same cycle yield a count of 1.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module parity_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_count_nxt;

  // Clear first, then count, stopping at all-ones
  always_comb begin
    w_base      = clr ? '0 : r_count;
    w_count_nxt = w_base;
    if (inc && (w_base != c_MAX)) begin
      w_count_nxt = w_base + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;

endmodule : parity_err_counter

`default_nettype wire

// File: rtl/parity_rx_checker.sv
// +------------------------------------------------------------------------+
// | Module   : parity_rx_checker                                           |
// | Purpose  : Serial frame receiver: DATA_BITS data bits (MSB first)      |
// |            followed by one parity bit. Rebuilds the word, flags parity |
// |            mismatches and optionally counts them.                      |
// | Options  : PARITY_RX_ERRCNT_EN - build the saturating error counter    |
// |            and honour err_clr; otherwise err_count is tied to zero.    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module parity_rx_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 3,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_par_err,
  output logic [CNT_W-1:0]     err_count
);

  localparam int               c_IDX_W    = pr_idx_width(DATA_BITS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
  localparam logic             c_ODD      = (ODD_PARITY != 0);

  pr_state_t            r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic                 r_acc, w_acc_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 w_frame_done;
  logic                 w_mismatch;
  logic                 r_out_valid;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_par_err;

  // FSM state, bit index, parity accumulator and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PR_DATA;
      r_idx   <= '0;
      r_acc   <= 1'b0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: everything holds while in_valid is low
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_acc_nxt    = r_acc;
    w_shift_nxt  = r_shift;
    w_frame_done = 1'b0;
    w_mismatch   = r_acc ^ in_bit ^ c_ODD;
    case (r_state)
      PR_DATA: begin
        if (in_valid) begin
          w_shift_nxt = {r_shift[DATA_BITS-2:0], in_bit};
          w_acc_nxt   = r_acc ^ in_bit;
          if (r_idx == c_LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = PR_PARITY;
          end else begin
            w_idx_nxt = r_idx + c_IDX_W'(1);
          end
        end
      end
      PR_PARITY: begin
        if (in_valid) begin
          w_frame_done = 1'b1;
          w_acc_nxt    = 1'b0;
          w_idx_nxt    = '0;
          w_state_nxt  = PR_DATA;
        end
      end
      default: begin
        w_state_nxt = PR_DATA;
        w_idx_nxt   = '0;
        w_acc_nxt   = 1'b0;
      end
    endcase
  end

  // Frame outputs: one-cycle valid pulse, data/error held until next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_par_err <= 1'b0;
    end else begin
      r_out_valid <= w_frame_done;
      if (w_frame_done) begin
        r_out_data    <= r_shift;
        r_out_par_err <= w_mismatch;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_par_err = r_out_par_err;

`ifdef PARITY_RX_ERRCNT_EN
  parity_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (err_clr),
    .inc   (w_frame_done & w_mismatch),
    .count (err_count)
  );
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_count        = '0;
`endif

endmodule : parity_rx_checker

`default_nettype wire

// File: tb/tb_parity_rx_checker.sv
// +------------------------------------------------------------------------+
// | Module   : tb_parity_rx_checker                                        |
// | Purpose  : Self-checking bench for parity_rx_checker. Three instances: |
// |            default, CNT_W=2 and ODD_PARITY=1. Works with or without    |
// |            PARITY_RX_ERRCNT_EN defined.                                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_parity_rx_checker;

  logic clk = 1'b0;
  logic rst;
  logic vld [3];
  logic bitv[3];
  logic clr [3];

  logic       ov[3];
  logic [2:0] od[3];
  logic       pe[3];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_rx_checker #(.DATA_BITS(3), .ODD_PARITY(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_bit(bitv[0]), .err_clr(clr[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_par_err(pe[0]), .err_count(cnt0));

  parity_rx_checker #(.DATA_BITS(3), .ODD_PARITY(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_bit(bitv[1]), .err_clr(clr[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_par_err(pe[1]), .err_count(cnt1));

  parity_rx_checker #(.DATA_BITS(3), .ODD_PARITY(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_bit(bitv[2]), .err_clr(clr[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_par_err(pe[2]), .err_count(cnt2));

  // ---------------- reference model (frame-level, queue based) ----------
  int m_q[3][$];
  int m_valid[3];
  int m_data[3];
  int m_perr[3];
  int m_cnt[3];
  int c_odd[3] = '{0, 0, 1};
  int c_max[3] = '{255, 3, 255};

  // Counter value as seen at the port in this build
  function automatic int ecnt(input int x);
`ifdef PARITY_RX_ERRCNT_EN
    return x;
`else
    return 0;
`endif
  endfunction

  function automatic int dut_cnt(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // Apply this cycle's inputs to the model: collect 4 bits, then judge
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_q[d].delete();
        m_valid[d] = 0; m_data[d] = 0; m_perr[d] = 0; m_cnt[d] = 0;
      end else begin
        m_valid[d] = 0;
        if (clr[d]) m_cnt[d] = 0;
        if (vld[d]) begin
          m_q[d].push_back(int'(bitv[d]));
          if (m_q[d].size() == 4) begin
            int ones;
            ones = m_q[d][0] + m_q[d][1] + m_q[d][2] + m_q[d][3];
            m_data[d]  = 4 * m_q[d][0] + 2 * m_q[d][1] + m_q[d][2];
            // even: total ones must be even; odd: total ones must be odd
            m_perr[d]  = ((ones % 2) != c_odd[d]) ? 1 : 0;
            m_valid[d] = 1;
            if (m_perr[d] == 1 && m_cnt[d] < c_max[d]) m_cnt[d]++;
            m_q[d].delete();
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: update model, advance, compare all instances
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_valid", d), int'(ov[d]), m_valid[d]);
      chk($sformatf("d%0d_data", d),  int'(od[d]), m_data[d]);
      chk($sformatf("d%0d_perr", d),  int'(pe[d]), m_perr[d]);
      chk($sformatf("d%0d_cnt", d),   dut_cnt(d),  ecnt(m_cnt[d]));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; bitv[d] = 1'b0; clr[d] = 1'b0;
    end
  endtask

  task automatic drive(input int d, input bit v, input bit b, input bit c);
    idle_all();
    vld[d] = v; bitv[d] = b; clr[d] = c;
  endtask

  // Send one frame (3 data bits + parity) back to back on instance d
  task automatic send_frame(input int d, input bit b2, input bit b1, input bit b0,
                            input bit p, input bit clr_last);
    drive(d, 1, b2, 0); tick();
    drive(d, 1, b1, 0); tick();
    drive(d, 1, b0, 0); tick();
    drive(d, 1, p, clr_last); tick();
    idle_all();
  endtask

  // ---------------- directed table for instance 0 -----------------------
  typedef struct {
    bit v; bit b; bit c;
    int ev; int ed; int ep; int ec;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit b, bit c, int ev, int ed, int ep, int ec);
    vec_t r;
    r.v = v; r.b = b; r.c = c; r.ev = ev; r.ed = ed; r.ep = ep; r.ec = ec;
    return r;
  endfunction

  initial begin
    // 1,0,1 / 0 -> 101 ok
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0));
    // 1,1,1 / 0 -> 111 error
    tbl.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 7, 1, 1));
    // 1,1,1 / 1 -> 111 ok, count stays
    tbl.push_back(mk(1, 1, 0, 0, 7, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 7, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 7, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 7, 0, 1));
    // 1,0,1 / 0 with 3-cycle gaps between bits
    tbl.push_back(mk(1, 1, 0, 0, 7, 0, 1));
    for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 1, 0, 0, 7, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 7, 0, 1));
    for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 0, 0, 0, 7, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 7, 0, 1));
    for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 1, 0, 0, 7, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 5, 0, 1));
    // err_clr alone
    tbl.push_back(mk(0, 0, 1, 0, 5, 0, 0));
  end

  // ---------------- main sequence ---------------------------------------
  initial begin
    int pulses;
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_valid", int'(ov[0]), 0);
    chk("reset_data",  int'(od[0]), 0);
    chk("reset_perr",  int'(pe[0]), 0);
    chk("reset_cnt",   int'(cnt0),  0);
    rst = 1'b0;

    // Table-driven vectors on instance 0
    pulses = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, tbl[i].v, tbl[i].b, tbl[i].c);
      tick();
      if (ov[0]) pulses++;
      chk($sformatf("tbl%0d_valid", i), int'(ov[0]), tbl[i].ev);
      chk($sformatf("tbl%0d_data", i),  int'(od[0]), tbl[i].ed);
      chk($sformatf("tbl%0d_perr", i),  int'(pe[0]), tbl[i].ep);
      chk($sformatf("tbl%0d_cnt", i),   int'(cnt0),  ecnt(tbl[i].ec));
    end
    chk("tbl_pulses", pulses, 4);
    idle_all();

    // Reset mid-frame: 1,1, reset (with a bit offered), then 0,1,1 / 0
    drive(0, 1, 1, 0); tick();
    drive(0, 1, 1, 0); tick();
    rst = 1'b1;
    drive(0, 1, 1, 1); tick();
    rst = 1'b0;
    chk("rstmid_valid", int'(ov[0]), 0);
    chk("rstmid_data",  int'(od[0]), 0);
    send_frame(0, 0, 1, 1, 0, 0);
    chk("rstmid_fr_valid", int'(ov[0]), 1);
    chk("rstmid_fr_data",  int'(od[0]), 3);
    chk("rstmid_fr_perr",  int'(pe[0]), 0);

    // CNT_W=2 saturation on instance 1
    for (int k = 0; k < 5; k++) begin
      send_frame(1, 1, 1, 1, 0, 0);
      chk($sformatf("sat%0d_perr", k), int'(pe[1]), 1);
      chk($sformatf("sat%0d_cnt", k),  int'(cnt1), ecnt((k < 3) ? k + 1 : 3));
    end
    send_frame(1, 1, 1, 1, 0, 1);
    chk("clr_and_err_cnt", int'(cnt1), ecnt(1));
    drive(1, 0, 0, 1); tick(); idle_all();
    chk("clr_alone_cnt", int'(cnt1), 0);

    // Odd parity on instance 2
    send_frame(2, 0, 0, 0, 1, 0);
    chk("odd_ok_perr", int'(pe[2]), 0);
    send_frame(2, 0, 0, 0, 0, 0);
    chk("odd_err_perr", int'(pe[2]), 1);
    chk("odd_err_cnt",  int'(cnt2),  ecnt(1));

    // Randomized traffic on all instances against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(299) == 0);
      for (int d = 0; d < 3; d++) begin
        vld[d]  = ($urandom_range(9) < 7);
        bitv[d] = 1'($urandom);
        clr[d]  = ($urandom_range(24) == 0);
      end
      tick();
    end
    rst = 1'b0;
    idle_all();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_parity_rx_checker

`default_nettype wire
